// File: rtl/ddr_rd_unpacker.sv
// -----------------------------------------------------------------------------
// ddr_rd_unpacker
//
// Buffers 128-bit beats from the DDR burst read port in a small FIFO and hands
// them to the data-cache side one DATA_WIDTH word at a time over valid/ready.
// The read port cannot be stalled, so beats that do not fit are dropped and
// flagged rather than back-pressured.
//
// Ports:
//   mem_clk             block clock
//   rst                 synchronous, active-high reset
//   start               one-cycle pulse; begins a transfer (only honoured in IDLE)
//   word_len            words to deliver; sampled on an accepted start
//   rd_burst_data_valid beat strobe from the burst read port
//   rd_burst_data       beat data
//   word_out            current output word (0 when word_valid is low)
//   word_valid          word_out is valid
//   word_ready          consumer accepts word_out
//   rd_cnt              words delivered in the current transfer
//   busy                high while a transfer is running
//   done                one-cycle pulse when the transfer completes
//   overflow            sticky: a beat was dropped because the FIFO was full
//   stray_beat          sticky: a beat arrived outside RUN or after all
//                       expected beats
//
// Build option:
//   UNPACK_MSB_FIRST_EN  when defined, the most-significant word of each beat
//                        is delivered first; otherwise the least-significant.
// -----------------------------------------------------------------------------
module ddr_rd_unpacker #(
    parameter int DDR_DATA_WIDTH = 128,
    parameter int DATA_WIDTH     = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int LEN_WIDTH      = 10
) (
    input  logic                      mem_clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [LEN_WIDTH-1:0]      word_len,
    input  logic                      rd_burst_data_valid,
    input  logic [DDR_DATA_WIDTH-1:0] rd_burst_data,
    output logic [DATA_WIDTH-1:0]     word_out,
    output logic                      word_valid,
    input  logic                      word_ready,
    output logic [LEN_WIDTH-1:0]      rd_cnt,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow,
    output logic                      stray_beat
);

    localparam int R      = DDR_DATA_WIDTH / DATA_WIDTH;
    localparam int SUB_W  = (R > 1) ? $clog2(R) : 1;
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    // One extra bit so the ceil-division add cannot wrap for the largest word_len.
    localparam int CNT_W  = LEN_WIDTH + 1;

    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(R - 1);
    localparam logic [CNT_W-1:0] R_CNT    = CNT_W'(R);
    localparam logic [CNT_W-1:0] R_M1     = CNT_W'(R - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [LEN_WIDTH-1:0]      word_len_q, word_len_d;
    logic [CNT_W-1:0]          exp_beats_q, exp_beats_d;
    logic [CNT_W-1:0]          beat_cnt_q, beat_cnt_d;
    logic [LEN_WIDTH-1:0]      rd_cnt_q, rd_cnt_d;
    logic [SUB_W-1:0]          sub_q, sub_d;
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic                      overflow_q, overflow_d;
    logic                      stray_q, stray_d;
    logic [DDR_DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];

    logic                         fifo_empty, fifo_full;
    logic [R-1:0][DATA_WIDTH-1:0] head_words;
    logic [SUB_W-1:0]             sub_sel;
    logic                         start_acc;
    logic                         hs, last_word, pop, push;
    logic                         beat_take, beat_drop_full, beat_stray;
    logic [LEN_WIDTH-1:0]         rd_cnt_inc;

    // -------------------------------------------------------------------------
    // FIFO status and head-word select
    // -------------------------------------------------------------------------
    // Pointers carry one wrap bit: equal pointers mean empty, equal addresses
    // with differing wrap bits mean full.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                        (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

    assign head_words = fifo_mem_q[rd_ptr_q[ADDR_W-1:0]];

`ifdef UNPACK_MSB_FIRST_EN
    assign sub_sel = SUB_LAST - sub_q;
`else
    assign sub_sel = sub_q;
`endif

    assign word_out = word_valid ? head_words[sub_sel] : '0;

    // -------------------------------------------------------------------------
    // Handshake, pop/push and beat classification
    // -------------------------------------------------------------------------
    assign start_acc  = start && (state_q == S_IDLE);
    assign hs         = word_valid && word_ready;
    assign rd_cnt_inc = rd_cnt_q + 1'b1;
    assign last_word  = hs && (rd_cnt_inc == word_len_q);
    // The head leaves after its last word, or early when the transfer ends
    // mid-beat.
    assign pop        = hs && ((sub_q == SUB_LAST) || last_word);

    // A beat counts against the expected total even when it is dropped for
    // lack of space, so an overflowing transfer still stops accepting beats.
    assign beat_take      = (state_q == S_RUN) && rd_burst_data_valid &&
                            (beat_cnt_q < exp_beats_q);
    assign push           = beat_take && (!fifo_full || pop);
    assign beat_drop_full = beat_take && fifo_full && !pop;
    assign beat_stray     = rd_burst_data_valid && !beat_take;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process evaluation order.
    always_ff @(posedge mem_clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (word_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_word) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        word_valid = 1'b0;
        unique case (state_q)
            S_RUN: begin
                busy       = 1'b1;
                word_valid = !fifo_empty;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath next-state
    // -------------------------------------------------------------------------
    always_comb begin
        word_len_d  = word_len_q;
        exp_beats_d = exp_beats_q;
        beat_cnt_d  = beat_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        sub_d       = sub_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        stray_d     = stray_q;

        if (start_acc) begin
            word_len_d  = word_len;
            exp_beats_d = ({1'b0, word_len} + R_M1) / R_CNT;
            beat_cnt_d  = '0;
            rd_cnt_d    = '0;
            sub_d       = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            overflow_d  = 1'b0;
            stray_d     = 1'b0;
        end

        if (beat_take) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (hs) begin
            rd_cnt_d = rd_cnt_inc;
            sub_d    = pop ? '0 : sub_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        // Residual entries (unused words of a partial last beat) are flushed.
        if (state_q == S_DONE) begin
            rd_ptr_d = wr_ptr_q;
            sub_d    = '0;
        end

        // Set after the start clear so a beat landing in the start cycle is
        // still reported.
        if (beat_drop_full) begin
            overflow_d = 1'b1;
        end
        if (beat_stray) begin
            stray_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge mem_clk) begin
        if (rst) begin
            word_len_q  <= '0;
            exp_beats_q <= '0;
            beat_cnt_q  <= '0;
            rd_cnt_q    <= '0;
            sub_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            stray_q     <= 1'b0;
        end else begin
            word_len_q  <= word_len_d;
            exp_beats_q <= exp_beats_d;
            beat_cnt_q  <= beat_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            sub_q       <= sub_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            stray_q     <= stray_d;
        end
    end

    // NOTE: the beat storage has no reset; entries are only read between a
    // push and its pop, and the pointers (which are reset) define validity.
    always_ff @(posedge mem_clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q[ADDR_W-1:0]] <= rd_burst_data;
        end
    end

    assign rd_cnt     = rd_cnt_q;
    assign overflow   = overflow_q;
    assign stray_beat = stray_q;

endmodule
